// File: rtl/extbus_bridge.sv
// extbus_bridge: converts cache external-bus requests (line fills, writebacks,
// uncached accesses) into doubleword beats on a req/ack memory port and
// returns per-beat read replies tagged with their source.
// Optional feature: define EXTBUS_TIMEOUT_EN to add a per-beat watchdog that
// completes a stalled beat as an errored beat after 255 phi2 periods.
module extbus_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        phi2,
  input  logic        extreq,
  input  logic        extwr,
  input  logic        extsrc,
  input  logic [31:0] extaddr,
  input  logic [4:0]  extsz,
  input  logic [63:0] extwdata,
  output logic        extrdy,
  output logic        extreply,
  output logic        extreplyto,
  output logic [63:0] extrdata,
  output logic        exterror,
  output logic        mem_req,
  output logic        mem_we,
  output logic [28:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err
);

  localparam int unsigned DW_AW  = 29;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = 8;

  typedef enum logic [1:0] {IDLE, WDATA2, MEMRD, MEMWR} state_t;

  state_t              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [1:0]          last_q, last_d;
  logic [DW_AW-1:0]    dwa_q, dwa_d;
  logic                src_q, src_d;
  logic [DATA_W-1:0]   wbuf_q, wbuf_d;
  logic                extreply_q, extreply_d;
  logic                extreplyto_q, extreplyto_d;
  logic [DATA_W-1:0]   extrdata_q, extrdata_d;
  logic                exterror_q, exterror_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [DW_AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;

  logic                accept;
  logic                tmo;
  logic                ack_eff;
  logic [DATA_W-1:0]   rdata_eff;
  logic                err_eff;
  logic [3:0]          tot;
  logic [DATA_W-1:0]   sw_data;
  logic [BE_W-1:0]     sw_be;

  // Doubleword address of beat i: wraps within the block (critical word first)
  function automatic logic [DW_AW-1:0] beat_addr(input logic [DW_AW-1:0] a,
                                                 input logic [1:0] last,
                                                 input logic [1:0] i);
    logic [1:0] lo;
    lo = a[1:0] + i;
    case (last)
      2'd3:    beat_addr = {a[DW_AW-1:2], lo};
      2'd1:    beat_addr = {a[DW_AW-1:1], a[0] ^ i[0]};
      default: beat_addr = a;
    endcase
  endfunction

  // Request acceptance is only possible in IDLE/WDATA2 and never during reset
  assign extrdy = !rst && ((state_q == IDLE) || (state_q == WDATA2));
  assign accept = extreq && extrdy;

  // Single-write lane placement: big-endian bytes o..o+sz, overflow past byte 7 dropped
  always_comb begin
    tot = 4'(extsz[2:0]) + 4'(extaddr[2:0]);
    if (tot <= 4'd7) begin
      sw_data = extwdata << {3'(4'd7 - tot), 3'b000};
    end else begin
      sw_data = extwdata >> {3'(tot - 4'd7), 3'b000};
    end
    sw_be = '0;
    for (int j = 0; j < int'(BE_W); j++) begin
      sw_be[j] = (3'(j) <= ~extaddr[2:0]) && ((5'(j) + 5'(tot)) >= 5'd7);
    end
  end

`ifdef EXTBUS_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;

  // Watchdog: counts stalled request periods, fires on the 255th
  always_comb begin
    tmo    = mem_req_q && !mem_ack && (wdog_q == 8'd254);
    wdog_d = (mem_req_q && !mem_ack && !tmo) ? wdog_q + 8'd1 : 8'd0;
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= 8'd0;
    end else if (phi2) begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // A timed-out beat completes like an ack carrying an error and zero data
  assign ack_eff   = mem_ack || tmo;
  assign rdata_eff = mem_ack ? mem_rdata : '0;
  assign err_eff   = mem_ack ? mem_err : 1'b1;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    last_d       = last_q;
    dwa_d        = dwa_q;
    src_d        = src_q;
    wbuf_d       = wbuf_q;
    extreply_d   = 1'b0;
    extreplyto_d = extreplyto_q;
    extrdata_d   = extrdata_q;
    exterror_d   = exterror_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          src_d  = extsrc;
          beat_d = 2'd0;
          if (!extwr) begin
            last_d     = (extsz == 5'd31) ? 2'd3 : ((extsz == 5'd15) ? 2'd1 : 2'd0);
            dwa_d      = extaddr[31:3];
            mem_addr_d = extaddr[31:3];
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_be_d   = 8'hFF;
            state_d    = MEMRD;
          end else if (extsz == 5'd15) begin
            last_d      = 2'd1;
            dwa_d       = {extaddr[31:4], 1'b0};
            mem_wdata_d = extwdata;
            state_d     = WDATA2;
          end else begin
            last_d      = 2'd0;
            dwa_d       = extaddr[31:3];
            mem_addr_d  = extaddr[31:3];
            mem_wdata_d = sw_data;
            mem_be_d    = sw_be;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            state_d     = MEMWR;
          end
        end
      end
      WDATA2: begin
        if (accept) begin
          wbuf_d     = extwdata;
          mem_addr_d = dwa_q;
          mem_be_d   = 8'hFF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          state_d    = MEMWR;
        end
      end
      MEMRD: begin
        if (ack_eff) begin
          extreply_d   = 1'b1;
          extreplyto_d = src_q;
          extrdata_d   = rdata_eff;
          exterror_d   = err_eff;
          if (beat_q == last_q) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end else begin
            beat_d     = beat_q + 2'd1;
            mem_addr_d = beat_addr(dwa_q, last_q, beat_q + 2'd1);
          end
        end
      end
      MEMWR: begin
        if (ack_eff) begin
          if (beat_q == last_q) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            state_d   = IDLE;
          end else begin
            beat_d      = beat_q + 2'd1;
            mem_addr_d  = beat_addr(dwa_q, last_q, beat_q + 2'd1);
            mem_wdata_d = wbuf_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins, otherwise advance on phi2 only
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= 2'd0;
      last_q       <= 2'd0;
      dwa_q        <= '0;
      src_q        <= 1'b0;
      wbuf_q       <= '0;
      extreply_q   <= 1'b0;
      extreplyto_q <= 1'b0;
      extrdata_q   <= '0;
      exterror_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
    end else if (phi2) begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      last_q       <= last_d;
      dwa_q        <= dwa_d;
      src_q        <= src_d;
      wbuf_q       <= wbuf_d;
      extreply_q   <= extreply_d;
      extreplyto_q <= extreplyto_d;
      extrdata_q   <= extrdata_d;
      exterror_q   <= exterror_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
    end
  end

  assign extreply   = extreply_q;
  assign extreplyto = extreplyto_q;
  assign extrdata   = extrdata_q;
  assign exterror   = exterror_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;

endmodule
